// File: rtl/nf_target_emu.sv
// nf_target_emu: single-CE 8-bit small-page NAND flash target emulator.
// The pads are oversampled in nfc_clk and cycles are decoded from strobe edges.
module nf_target_emu #(
  parameter int         PAGE_BYTES = 528,
  parameter int         NUM_PAGES  = 4,
  parameter int         T_R        = 600,
  parameter int         T_PROG     = 1000,
  parameter int         T_ERASE    = 2000,
  parameter int         T_RST      = 50,
  parameter logic [7:0] MAKER_ID   = 8'h20,
  parameter logic [7:0] DEVICE_ID  = 8'h75
) (
  input  logic       nfc_clk,
  input  logic       rst_nfc,
  input  logic       nf_ceb_i,
  input  logic       nf_cle_i,
  input  logic       nf_ale_i,
  input  logic       nf_web_i,
  input  logic       nf_reb_i,
  input  logic       nf_wpb_i,
  input  logic [7:0] nf_dat_i,
  output logic [7:0] nf_dat_o,
  output logic       nf_dat_oe,
  output logic       nf_rnb_o,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DIN, S_BUSY_LOAD, S_BUSY_PROG,
    S_BUSY_ERASE, S_BUSY_RST, S_DOUT, S_STATUS, S_ID
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE, OP_ID} op_t;
  typedef enum logic [1:0] {AREA_A, AREA_B, AREA_C} area_t;

  localparam int AW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int CW = $clog2(PAGE_BYTES);
  localparam int PW = (CW + 1 > 10) ? CW + 1 : 10;

  localparam logic [PW-1:0] PB_P      = PW'(PAGE_BYTES);
  localparam logic [15:0]   PB_C      = 16'(PAGE_BYTES);
  localparam logic [15:0]   TR_LAST   = 16'(T_R - 1);
  localparam logic [15:0]   TP_LAST   = 16'(T_PROG - 1);
  localparam logic [15:0]   TE_LAST   = 16'(T_ERASE - 1);
  localparam logic [15:0]   TRST_LAST = 16'(T_RST - 1);

  // Strobe protocol: a bus cycle is taken on the web rising edge with the
  // cle/ale/dat values sampled alongside it; reb low requests the byte at the
  // pointer and the reb rising edge advances the pointer. ceb high masks both.
  logic       s_ceb, s_cle, s_ale, s_web, s_reb, s_wpb;
  logic [7:0] s_dat;
  logic       d_ceb, d_web, d_reb;

  state_t         state, state_n;
  op_t            op;
  area_t          area;
  logic [1:0]     acnt;
  logic [7:0]     col;
  logic [AW-1:0]  page;
  logic [PW-1:0]  ptr;
  logic [15:0]    cnt;
  logic [1:0]     id_idx;
  logic           fail, wp_blk, stat_mode, rnb;

  logic [7:0] page_reg [PAGE_BYTES];
  logic [7:0] mem      [NUM_PAGES][PAGE_BYTES];

  logic web_rise, reb_rise, ceb_rise;
  logic is_cmd, is_addr, is_data;
  logic busy, restart, enter_busy, erase_ready;
  logic [CW-1:0] ptr_idx, cnt_idx;
  logic       out_en;
  logic [7:0] out_val;

  function automatic logic is_busy(input state_t s);
    return s inside {S_BUSY_LOAD, S_BUSY_PROG, S_BUSY_ERASE, S_BUSY_RST};
  endfunction

  function automatic logic [PW-1:0] col_offset(input area_t a, input logic [7:0] c);
    case (a)
      AREA_B:  return PW'(256) + PW'(c);
      AREA_C:  return PW'(512) + PW'(c[3:0]);
      default: return PW'(c);
    endcase
  endfunction

  always_ff @(posedge nfc_clk) begin
    if (rst_nfc) begin
      s_ceb <= 1'b1; s_cle <= 1'b0; s_ale <= 1'b0; s_web <= 1'b1;
      s_reb <= 1'b1; s_wpb <= 1'b1; s_dat <= 8'h00;
      d_ceb <= 1'b1; d_web <= 1'b1; d_reb <= 1'b1;
    end else begin
      s_ceb <= nf_ceb_i; s_cle <= nf_cle_i; s_ale <= nf_ale_i; s_web <= nf_web_i;
      s_reb <= nf_reb_i; s_wpb <= nf_wpb_i; s_dat <= nf_dat_i;
      d_ceb <= s_ceb; d_web <= s_web; d_reb <= s_reb;
    end
  end

  assign web_rise = s_web & ~d_web & ~s_ceb;
  assign reb_rise = s_reb & ~d_reb & ~s_ceb;
  assign ceb_rise = s_ceb & ~d_ceb;
  assign is_cmd   = web_rise &  s_cle & ~s_ale;
  assign is_addr  = web_rise & ~s_cle &  s_ale;
  assign is_data  = web_rise & ~s_cle & ~s_ale;

  assign busy        = is_busy(state);
  assign restart     = busy & is_cmd & (s_dat == 8'hFF);
  assign erase_ready = (state == S_ADDR) && (op == OP_ERASE) && (acnt == 2'd2);
  assign ptr_idx     = ptr[CW-1:0];
  assign cnt_idx     = cnt[CW-1:0];

  always_comb begin
    state_n = state;
    case (state)
      S_BUSY_LOAD:  if (cnt == TR_LAST)   state_n = S_DOUT;
      S_BUSY_PROG:  if (cnt == TP_LAST)   state_n = stat_mode ? S_STATUS : S_IDLE;
      S_BUSY_ERASE: if (cnt == TE_LAST)   state_n = stat_mode ? S_STATUS : S_IDLE;
      S_BUSY_RST:   if (cnt == TRST_LAST) state_n = stat_mode ? S_STATUS : S_IDLE;
      default: ;
    endcase
    if (busy) begin
      if (restart) state_n = S_BUSY_RST;
    end else if (is_cmd) begin
      case (s_dat)
        8'h00, 8'h01, 8'h50, 8'h80, 8'h60, 8'h90: state_n = S_ADDR;
        8'h10:   state_n = (state == S_DIN) ? S_BUSY_PROG : S_IDLE;
        8'hD0:   state_n = erase_ready ? S_BUSY_ERASE : S_IDLE;
        8'h70:   state_n = S_STATUS;
        8'hFF:   state_n = S_BUSY_RST;
        default: state_n = S_IDLE;
      endcase
    end else if (is_addr) begin
      if (state == S_ADDR) begin
        case (op)
          OP_READ: if (acnt == 2'd2) state_n = S_BUSY_LOAD;
          OP_PROG: if (acnt == 2'd2) state_n = S_DIN;
          OP_ID:   state_n = S_ID;
          default: ;
        endcase
      end else if (state == S_IDLE || state == S_DOUT) begin
        state_n = S_ADDR;
      end
    end else if (ceb_rise) begin
      if (state inside {S_ADDR, S_DIN, S_DOUT, S_STATUS, S_ID}) state_n = S_IDLE;
    end
  end

  assign enter_busy = is_busy(state_n) && ((state_n != state) || restart);

  always_ff @(posedge nfc_clk) begin
    if (rst_nfc) state <= S_IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge nfc_clk) begin
    if (rst_nfc) begin
      op <= OP_READ; area <= AREA_A; acnt <= 2'd0; col <= 8'h00;
      page <= '0; ptr <= '0; cnt <= '0; id_idx <= 2'd0;
      fail <= 1'b0; wp_blk <= 1'b0; stat_mode <= 1'b0; rnb <= 1'b1;
    end else begin
      rnb <= !is_busy(state_n);
      if (enter_busy)  cnt <= '0;
      else if (busy)   cnt <= cnt + 16'd1;

      // Status requested during busy is shown until the next command.
      if (!busy)       stat_mode <= 1'b0;
      else if (is_cmd) stat_mode <= (s_dat == 8'h70) ? 1'b1 :
                                    (s_dat == 8'hFF) ? 1'b0 : stat_mode;

      if (busy) begin
        if (restart) begin
          area <= AREA_A;
          if (state == S_BUSY_PROG || state == S_BUSY_ERASE) fail <= 1'b1;
        end
      end else if (is_cmd) begin
        acnt <= 2'd0;
        case (s_dat)
          8'h00: begin area <= AREA_A; op <= OP_READ; end
          8'h01: begin area <= AREA_B; op <= OP_READ; end
          8'h50: begin area <= AREA_C; op <= OP_READ; end
          8'h80: begin op <= OP_PROG;  fail <= 1'b0; end
          8'h60: begin op <= OP_ERASE; fail <= 1'b0; end
          8'h90: op <= OP_ID;
          8'h10: if (state == S_DIN) begin
                   wp_blk <= ~s_wpb;
                   if (!s_wpb) fail <= 1'b1;
                 end
          8'hD0: if (erase_ready) begin
                   wp_blk <= ~s_wpb;
                   if (!s_wpb) fail <= 1'b1;
                 end
          8'hFF: area <= AREA_A;
          default: ;
        endcase
      end else if (is_addr) begin
        if (state == S_ADDR) begin
          if (!(op == OP_ERASE && acnt == 2'd2)) acnt <= acnt + 2'd1;
          if (op == OP_ID) begin
            id_idx <= 2'd0;
          end else if (op != OP_ERASE) begin
            case (acnt)
              2'd0:    col  <= s_dat;
              2'd1:    page <= s_dat[AW-1:0];
              default: begin
                ptr <= col_offset(area, col);
                if (area == AREA_B) area <= AREA_A;
              end
            endcase
          end
        end else if (state == S_IDLE || state == S_DOUT) begin
          // Address cycles without a preceding command start a read.
          op   <= OP_READ;
          acnt <= 2'd1;
          col  <= s_dat;
        end
      end else if (is_data) begin
        if (state == S_DIN && ptr < PB_P) ptr <= ptr + PW'(1);
      end else if (reb_rise) begin
        if (state == S_DOUT && ptr < PB_P) ptr <= ptr + PW'(1);
        if (state == S_ID && id_idx != 2'd2) id_idx <= id_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge nfc_clk) begin
    if (!busy && is_cmd && s_dat == 8'h80) begin
      for (int i = 0; i < PAGE_BYTES; i++) page_reg[i] <= 8'hFF;
    end else if (state == S_BUSY_LOAD && cnt < PB_C) begin
      page_reg[cnt_idx] <= mem[page][cnt_idx];
    end else if (state == S_DIN && is_data && ptr < PB_P) begin
      page_reg[ptr_idx] <= s_dat;
    end
  end

  // Program can only clear bits; erase sweeps one column of every page per cycle.
  always_ff @(posedge nfc_clk) begin
    if (!rst_nfc && !wp_blk && cnt < PB_C) begin
      if (state == S_BUSY_PROG) begin
        mem[page][cnt_idx] <= mem[page][cnt_idx] & page_reg[cnt_idx];
      end else if (state == S_BUSY_ERASE) begin
        for (int p = 0; p < NUM_PAGES; p++) mem[p][cnt_idx] <= 8'hFF;
      end
    end
  end

  always_comb begin
    out_en  = 1'b0;
    out_val = 8'hFF;
    if (state == S_STATUS || (busy && stat_mode)) begin
      out_en  = 1'b1;
      out_val = {s_wpb, rnb, 5'b0, fail};
    end else if (state == S_DOUT) begin
      out_en  = 1'b1;
      out_val = (ptr < PB_P) ? page_reg[ptr_idx] : 8'hFF;
    end else if (state == S_ID) begin
      out_en  = 1'b1;
      out_val = (id_idx == 2'd0) ? MAKER_ID : (id_idx == 2'd1) ? DEVICE_ID : 8'hFF;
    end
  end

  always_ff @(posedge nfc_clk) begin
    if (rst_nfc) begin
      nf_dat_o  <= 8'hFF;
      nf_dat_oe <= 1'b0;
    end else begin
      nf_dat_oe <= out_en & ~s_reb & ~s_ceb;
      nf_dat_o  <= (out_en & ~s_reb & ~s_ceb) ? out_val : 8'hFF;
    end
  end

  assign nf_rnb_o  = rnb;
  assign dbg_state = state;

endmodule
